// File: rtl/video_tap_select_if.sv
// video_tap_select_if
//   Bundles the per-tap video streams that feed the selector and the
//   single selected stream it produces.
//   master : drives the tap streams, observes the selected stream
//            (pipeline side / testbench)
//   slave  : consumes the tap streams, drives the selected stream
//            (video_tap_select)
//   Tap signals: i_data (NUM_TAPS*DATA_W), i_hsync, i_vsync, i_de (NUM_TAPS)
//   Selected   : o_data (DATA_W), o_hsync, o_vsync, o_de
interface video_tap_select_if #(
  parameter int DATA_W   = 24,
  parameter int NUM_TAPS = 4
);
  logic [NUM_TAPS*DATA_W-1:0] i_data;
  logic [NUM_TAPS-1:0]        i_hsync;
  logic [NUM_TAPS-1:0]        i_vsync;
  logic [NUM_TAPS-1:0]        i_de;

  logic [DATA_W-1:0]          o_data;
  logic                       o_hsync;
  logic                       o_vsync;
  logic                       o_de;

  modport master (
    output i_data, i_hsync, i_vsync, i_de,
    input  o_data, o_hsync, o_vsync, o_de
  );

  modport slave (
    input  i_data, i_hsync, i_vsync, i_de,
    output o_data, o_hsync, o_vsync, o_de
  );
endinterface

// File: rtl/video_tap_select.sv
// video_tap_select
//   Selects one of NUM_TAPS video streams for the output encoder. Tap
//   changes are deferred to a frame start of the active tap, followed by a
//   blanked hand-over that ends on a frame start of the new tap (or after
//   TIMEOUT cycles), so the display only ever sees whole frames.
//   Ports:
//     pixelclk      pixel clock
//     reset         synchronous, active-high reset
//     sel           requested tap (out-of-range values mean tap 0)
//     vif           tap streams in, selected stream out (registered)
//     o_active_sel  tap currently driving the output
//     o_switching   high while blanking during a hand-over
//     o_timeout     sticky, set when a hand-over was forced by timeout
//
//   state | meaning
//   RUN   | output copies tap o_active_sel, waits for a change request
//   BLANK | data/de forced to 0, syncs from target, waits for target frame
module video_tap_select #(
  parameter int DATA_W   = 24,
  parameter int NUM_TAPS = 4,
  parameter int SEL_W    = 3,
  parameter bit VS_POL   = 1'b1,
  parameter int TIMEOUT  = 2000000
) (
  input  logic             pixelclk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  video_tap_select_if.slave vif,
  output logic [SEL_W-1:0] o_active_sel,
  output logic             o_switching,
  output logic             o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_RUN, ST_BLANK} state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_active_sel;
  logic [SEL_W-1:0]    r_target;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_TAPS-1:0] r_vs_prev;
  logic                r_timeout;
  logic [DATA_W-1:0]   r_data;
  logic                r_hsync;
  logic                r_vsync;
  logic                r_de;

  state_t              w_state_nxt;
  logic [SEL_W-1:0]    w_active_nxt;
  logic [SEL_W-1:0]    w_target_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_timeout_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_hsync_nxt;
  logic                w_vsync_nxt;
  logic                w_de_nxt;

  logic [SEL_W-1:0]    w_sel_eff;
  logic [SEL_W-1:0]    w_src;
  logic [NUM_TAPS-1:0] w_fs;
  logic [DATA_W-1:0]   w_src_data;
  logic                w_src_hsync;
  logic                w_src_vsync;
  logic                w_src_de;
  logic                w_src_fs;
  logic                w_cnt_tc;

  assign w_sel_eff = (32'(sel) < NUM_TAPS) ? sel : '0;

  // Frame start: vsync enters its active level this cycle.
  assign w_fs = VS_POL ? (vif.i_vsync & ~r_vs_prev) : (~vif.i_vsync & r_vs_prev);

  // RUN watches the active tap, BLANK watches the target; one mux serves both.
  assign w_src    = (r_state == ST_BLANK) ? r_target : r_active_sel;
  assign w_cnt_tc = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_src_data  = '0;
    w_src_hsync = 1'b0;
    w_src_vsync = 1'b0;
    w_src_de    = 1'b0;
    w_src_fs    = 1'b0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (w_src == SEL_W'(k)) begin
        w_src_data  = vif.i_data[k*DATA_W +: DATA_W];
        w_src_hsync = vif.i_hsync[k];
        w_src_vsync = vif.i_vsync[k];
        w_src_de    = vif.i_de[k];
        w_src_fs    = w_fs[k];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_active_nxt  = r_active_sel;
    w_target_nxt  = r_target;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
    w_data_nxt    = w_src_data;
    w_hsync_nxt   = w_src_hsync;
    w_vsync_nxt   = w_src_vsync;
    w_de_nxt      = w_src_de;
    case (r_state)
      ST_RUN: begin
        // A request only matters if it is still standing at the frame start.
        if (w_src_fs && (w_sel_eff != r_active_sel)) begin
          w_state_nxt  = ST_BLANK;
          w_target_nxt = w_sel_eff;
          w_cnt_nxt    = '0;
        end
      end
      ST_BLANK: begin
        w_data_nxt = '0;
        w_de_nxt   = 1'b0;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (w_src_fs || w_cnt_tc) begin
          w_state_nxt  = ST_RUN;
          w_active_nxt = r_target;
          if (w_cnt_tc) w_timeout_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_active_sel <= '0;
      r_target     <= '0;
      r_cnt        <= '0;
      r_vs_prev    <= {NUM_TAPS{~VS_POL}};
      r_timeout    <= 1'b0;
      r_data       <= '0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_de         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_sel <= w_active_nxt;
      r_target     <= w_target_nxt;
      r_cnt        <= w_cnt_nxt;
      r_vs_prev    <= vif.i_vsync;
      r_timeout    <= w_timeout_nxt;
      r_data       <= w_data_nxt;
      r_hsync      <= w_hsync_nxt;
      r_vsync      <= w_vsync_nxt;
      r_de         <= w_de_nxt;
    end
  end

  assign vif.o_data    = r_data;
  assign vif.o_hsync   = r_hsync;
  assign vif.o_vsync   = r_vsync;
  assign vif.o_de      = r_de;
  assign o_active_sel  = r_active_sel;
  assign o_switching   = (r_state == ST_BLANK);
  assign o_timeout     = r_timeout;

endmodule

// File: doc/video_tap_select.md
Name: video_tap_select

Overview:
- Parametrised, registered successor to the switch-driven stage selector at the top of the defog pipeline.
- Selects one of NUM_TAPS video streams (data, hsync, vsync, de) for the output. Typical taps: raw, dark channel, transmittance, defogged.
- Tap changes take effect only at frame boundaries, with a blanked hand-over, so the display never sees a torn or partial frame.
- Sits between the pipeline stage outputs and the video output encoder.

Parameters:
- DATA_W, 24, pixel width per tap.
- NUM_TAPS, 4, number of input streams (2..8).
- SEL_W, 3, width of the select input.
- VS_POL, 1, vsync active level (1 = active-high). A frame start is the transition of the selected tap's vsync into this level.
- TIMEOUT, 2000000, maximum pixelclk cycles spent in BLANK before a forced hand-over.

Ports:
- pixelclk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- sel  in  SEL_W  requested tap index (binary). Values >= NUM_TAPS select tap 0.
- i_data  in  NUM_TAPS*DATA_W  tap pixel buses; tap k occupies bits [k*DATA_W +: DATA_W].
- i_hsync  in  NUM_TAPS  per-tap hsync.
- i_vsync  in  NUM_TAPS  per-tap vsync.
- i_de  in  NUM_TAPS  per-tap data enable.
- o_data  out  DATA_W  selected pixel, registered.
- o_hsync  out  1  selected hsync, registered.
- o_vsync  out  1  selected vsync, registered.
- o_de  out  1  selected data enable, registered.
- o_active_sel  out  SEL_W  tap currently driving the output.
- o_switching  out  1  high while in BLANK.
- o_timeout  out  1  sticky flag; set when a hand-over was forced by timeout.

Behaviour:
- All outputs are registered, one pixelclk of latency from tap inputs to outputs.
- Reset (synchronous, active-high):
  - o_data = 0; o_hsync, o_vsync, o_de = 0.
  - o_active_sel = 0, o_switching = 0, o_timeout = 0.
  - State = RUN, target = 0, timeout counter = 0, vs_prev = all taps at the inactive level.
- sel_eff = (sel < NUM_TAPS) ? sel : 0. sel_eff is evaluated every cycle.
- vs_prev holds every tap's vsync from the previous cycle. A frame start for tap k in a cycle is: i_vsync[k] == VS_POL and vs_prev[k] != VS_POL.
- State RUN:
  - Outputs copy tap o_active_sel.
  - Request pending when sel_eff != o_active_sel. A request that reverts before the next frame start is dropped and causes no switch.
  - On a frame start of tap o_active_sel with a request pending:
    - target <= sel_eff, counter <= 0.
    - Go to BLANK. o_switching rises the next cycle.
  - In that transition cycle, outputs still copy the old tap, then blanking begins.
- State BLANK:
  - o_data = 0, o_de = 0.
  - o_hsync and o_vsync copy tap target, so sync continuity is kept from the new source.
  - sel changes are ignored; target is fixed.
  - Counter increments every cycle.
- Exit from BLANK, on the first cycle where either holds:
  - a frame start of tap target, or
  - counter == TIMEOUT-1.
  - On exit: o_active_sel <= target, state <= RUN, o_switching <= 0. On the timeout path, o_timeout <= 1 as well.
  - Output copies tap target from the next registered cycle. The first frame shown is therefore complete.
- o_timeout clears only on reset.
- Simultaneous events:
  - Frame start on the old tap and the target tap in the same cycle: enter BLANK, then exit on the target's next frame start. A target frame start seen in the entry cycle does not count.
  - Both exit conditions in the same cycle: exit, and set o_timeout.
- Reset asserted in BLANK: immediate return to reset values. Tap 0 drives the output from the cycle after reset deasserts.

Test Plan:
1. Reset, then sel=0, NUM_TAPS=4, tap 0 data=0x112233 with de=1 -> o_data=0x112233 one cycle later; o_active_sel=0; o_switching=0.
2. Mid-frame, sel=2 -> output stays on tap 0 until tap 0 vsync goes active. Then o_switching=1, o_de=0, o_data=0 until tap 2 vsync goes active. Then o_active_sel=2 and o_data follows tap 2 with 1-cycle latency.
3. sel=1 for 100 cycles, then back to 0, all before tap 0 vsync goes active -> no BLANK, o_switching stays 0, o_active_sel=0.
4. sel=5 (out of range) while active tap is 3 -> at tap 3's next frame start, hand-over to tap 0; o_active_sel=0.
5. TIMEOUT=64, target tap vsync held inactive -> exactly 64 cycles in BLANK, then o_active_sel=target, o_timeout=1 and stays 1.
6. Reset pulsed in BLANK -> next cycle all outputs 0 and o_switching=0; tap 0 passes through afterwards.
